fprint_pointer_table: RTL
=========================

FPRINT_POINTER_TABLE -- requirements
Module: fprint_pointer_table

Interface
REQ-001 SHALL have parameter NUM_CORES, default 3, number of logical cores (1..4).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, task-id width; table depth 2**KEY_WIDTH tasks per core.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, fingerprint RAM pointer width.
REQ-004 SHALL use one clock and asynchronous active-high reset, ports as below.
REQ-005 SHALL have ports, in order:
 clk  in  1  clock
 reset  in  1  async active-high reset
 csr_core_id  in  2  core selected for pointer writes
 csr_task_id  in  KEY_WIDTH  task selected for pointer writes
 csr_start_write  in  1  level request: write start pointer
 csr_end_write  in  1  level request: write end pointer
 csr_pointer_data  in  ADDR_WIDTH  pointer value
 csr_ack  out  1  one-cycle completion pulse for start/end write
 fprint_core_id  in  2  producer core
 fprint_task_id  in  KEY_WIDTH  producer task
 fprint_inc_head  in  1  level request: advance head
 fprint_inc_head_ack  out  1  one-cycle completion pulse
 fprint_head_pointer  out  ADDR_WIDTH  head of (fprint_core_id, fprint_task_id)
 fprint_full  out  1  selected producer region full
 cmp_task_id  in  KEY_WIDTH  comparator task
 cmp_inc_tail  in  1  level request: advance tail, all cores
 cmp_inc_tail_ack  out  1  one-cycle completion pulse
 cmp_reset_task  in  1  level request: rewind task, all cores
 cmp_reset_task_ack  out  1  one-cycle completion pulse
 cmp_tail_pointer  out  NUM_CORES*ADDR_WIDTH  tails of cmp_task_id, core 0 in LSBs
 cmp_empty  out  NUM_CORES  per-core empty flag for cmp_task_id
 overflow_err  out  1  sticky: inc_head while full
 underflow_err  out  1  sticky: inc_tail while empty

Function
REQ-006 SHALL hold per (core, task): start, end, head, tail (ADDR_WIDTH) and count (ADDR_WIDTH+1).
REQ-007 SHALL use FSM IDLE -> EXEC -> ACK -> IDLE; one operation in flight.
REQ-008 SHALL, in IDLE, grant fixed priority: csr_start_write > csr_end_write > fprint_inc_head > cmp_inc_tail > cmp_reset_task; IDLE with no request stays IDLE.
REQ-009 SHALL capture selected ids and data at grant; input changes during EXEC/ACK ignored.
REQ-010 SHALL apply update at end of EXEC; matching ack high only in ACK (request seen at edge N -> ack during cycle N+2).
REQ-011 SHALL re-grant a request still asserted when FSM returns to IDLE; requesters drop on ack.
REQ-012 Start write SHALL set start, head, tail to data and count to 0; end write SHALL set end only.
REQ-013 inc_head SHALL set head to start if head==end else head+1, count+1; if count==end-start+1 (full), no change and overflow_err set.
REQ-014 inc_tail SHALL act on every core independently: tail wraps as head; count-1; core with count 0 unchanged, underflow_err set.
REQ-015 reset_task SHALL set head=tail=start and count=0 for cmp_task_id in every core.
REQ-016 Core id >= NUM_CORES SHALL produce ack with no state change.
REQ-017 fprint_head_pointer, fprint_full, cmp_tail_pointer, cmp_empty SHALL be combinational from table and current ids; out-of-range core reads 0 / full=0.
REQ-018 Pointer arithmetic SHALL be modulo 2**ADDR_WIDTH; end<start is a software error, behaviour then undefined except no X propagation.
REQ-019 overflow_err/underflow_err SHALL clear only on reset.

Reset
REQ-020 Reset SHALL force IDLE, all acks 0, all table entries 0, both error flags 0, within the asserting edge.
REQ-021 Reset mid-operation SHALL abort without ack; the pending update is not applied.

Verification
REQ-022 Core1 task3: start=0x100, end=0x103 -> csr_ack pulses twice; head=tail=0x100, fprint_full=0, cmp_empty[1]=1.
REQ-023 Four inc_head on core1 task3 -> heads 0x101,0x102,0x103,0x100; fprint_full=1; fifth inc_head -> ack, head 0x100, overflow_err=1.
REQ-024 csr_start_write and fprint_inc_head raised same cycle -> csr_ack at N+2, fprint_inc_head_ack at N+5.
REQ-025 cmp_inc_tail on task3 with core0 empty, core1 count 4 -> core1 tail 0x101, core0 unchanged, underflow_err=1.
REQ-026 cmp_reset_task task3 -> all cores head=tail=start, cmp_empty all 1; reset asserted during EXEC -> no ack, table zero.

Source files
------------

// File: rtl/fprint_pointer_table.sv
// fprint_pointer_table
// Per-(core, task) ring-buffer pointer table for a fingerprint RAM. Each entry
// holds a region [start, end], a producer head, a consumer tail and an
// occupancy count. A three-state sequencer (IDLE -> EXEC -> ACK) serialises
// CSR pointer writes, producer head advances, and comparator tail advances or
// task rewinds. The comparator operations act on one task across all cores.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   csr_*                 start/end pointer writes for (csr_core_id, csr_task_id)
//   csr_ack               one-cycle completion pulse for start/end writes
//   fprint_*              producer head advance and head/full lookup
//   cmp_*                 comparator tail advance / task rewind, tail/empty lookup
//   overflow_err          sticky: head advance attempted while region full
//   underflow_err         sticky: tail advance attempted on an empty core
module fprint_pointer_table #(
  parameter int NUM_CORES  = 3,
  parameter int KEY_WIDTH  = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      csr_core_id,
  input  logic [KEY_WIDTH-1:0]            csr_task_id,
  input  logic                            csr_start_write,
  input  logic                            csr_end_write,
  input  logic [ADDR_WIDTH-1:0]           csr_pointer_data,
  output logic                            csr_ack,
  input  logic [1:0]                      fprint_core_id,
  input  logic [KEY_WIDTH-1:0]            fprint_task_id,
  input  logic                            fprint_inc_head,
  output logic                            fprint_inc_head_ack,
  output logic [ADDR_WIDTH-1:0]           fprint_head_pointer,
  output logic                            fprint_full,
  input  logic [KEY_WIDTH-1:0]            cmp_task_id,
  input  logic                            cmp_inc_tail,
  output logic                            cmp_inc_tail_ack,
  input  logic                            cmp_reset_task,
  output logic                            cmp_reset_task_ack,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] cmp_tail_pointer,
  output logic [NUM_CORES-1:0]            cmp_empty,
  output logic                            overflow_err,
  output logic                            underflow_err
);

  localparam int DEPTH = 2 ** KEY_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         ONE_CNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_ACK = 2'd2} state_t;
  typedef enum logic [2:0] {
    OP_START = 3'd0, OP_END = 3'd1, OP_HEAD = 3'd2, OP_TAIL = 3'd3, OP_RTASK = 3'd4
  } op_t;

  logic [ADDR_WIDTH-1:0] start_r [NUM_CORES][DEPTH];
  logic [ADDR_WIDTH-1:0] end_r   [NUM_CORES][DEPTH];
  logic [ADDR_WIDTH-1:0] head_r  [NUM_CORES][DEPTH];
  logic [ADDR_WIDTH-1:0] tail_r  [NUM_CORES][DEPTH];
  logic [CW-1:0]         count_r [NUM_CORES][DEPTH];

  state_t                state_r;
  op_t                   op_r;
  logic [1:0]            core_r;
  logic [KEY_WIDTH-1:0]  task_r;
  logic [ADDR_WIDTH-1:0] data_r;
  logic                  csr_ack_r, head_ack_r, tail_ack_r, rtask_ack_r;
  logic                  overflow_r, underflow_r;

  logic                  req_any_s;
  op_t                   req_op_s;
  logic [1:0]            sel_core_s;
  logic [KEY_WIDTH-1:0]  sel_task_s;
  logic                  rd_ok_s;
  logic [1:0]            rd_idx_s;

  // Ring pointer advance: wrap from end back to start, otherwise increment.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p,
                                                     input logic [ADDR_WIDTH-1:0] s,
                                                     input logic [ADDR_WIDTH-1:0] e);
    next_ptr = (p == e) ? s : p + ONE_PTR;
  endfunction

  // Region capacity end-start+1, one bit wider so a full 2**ADDR_WIDTH region fits.
  function automatic logic [CW-1:0] region_size(input logic [ADDR_WIDTH-1:0] s,
                                                input logic [ADDR_WIDTH-1:0] e);
    region_size = {1'b0, e} - {1'b0, s} + ONE_CNT;
  endfunction

  // Fixed-priority request selection and the ids captured with the grant.
  always_comb begin
    req_any_s  = 1'b0;
    req_op_s   = OP_START;
    sel_core_s = csr_core_id;
    sel_task_s = csr_task_id;
    if (csr_start_write) begin
      req_any_s = 1'b1;
      req_op_s  = OP_START;
    end else if (csr_end_write) begin
      req_any_s = 1'b1;
      req_op_s  = OP_END;
    end else if (fprint_inc_head) begin
      req_any_s  = 1'b1;
      req_op_s   = OP_HEAD;
      sel_core_s = fprint_core_id;
      sel_task_s = fprint_task_id;
    end else if (cmp_inc_tail) begin
      req_any_s  = 1'b1;
      req_op_s   = OP_TAIL;
      sel_core_s = 2'd0;
      sel_task_s = cmp_task_id;
    end else if (cmp_reset_task) begin
      req_any_s  = 1'b1;
      req_op_s   = OP_RTASK;
      sel_core_s = 2'd0;
      sel_task_s = cmp_task_id;
    end else begin
      req_any_s = 1'b0;
    end
  end

  // Sequencer, table update and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_START;
      core_r      <= 2'd0;
      task_r      <= '0;
      data_r      <= '0;
      csr_ack_r   <= 1'b0;
      head_ack_r  <= 1'b0;
      tail_ack_r  <= 1'b0;
      rtask_ack_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int t = 0; t < DEPTH; t++) begin
          start_r[c][t] <= '0;
          end_r[c][t]   <= '0;
          head_r[c][t]  <= '0;
          tail_r[c][t]  <= '0;
          count_r[c][t] <= '0;
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            op_r    <= req_op_s;
            core_r  <= sel_core_s;
            task_r  <= sel_task_s;
            data_r  <= csr_pointer_data;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Single-core ops only touch an entry whose core index matches, so an
          // out-of-range core id completes with an ack and no table change.
          for (int c = 0; c < NUM_CORES; c++) begin
            for (int t = 0; t < DEPTH; t++) begin
              if (t == int'(task_r)) begin
                case (op_r)
                  OP_START: begin
                    if (c == int'(core_r)) begin
                      start_r[c][t] <= data_r;
                      head_r[c][t]  <= data_r;
                      tail_r[c][t]  <= data_r;
                      count_r[c][t] <= '0;
                    end
                  end
                  OP_END: begin
                    if (c == int'(core_r)) begin
                      end_r[c][t] <= data_r;
                    end
                  end
                  OP_HEAD: begin
                    if (c == int'(core_r)) begin
                      if (count_r[c][t] == region_size(start_r[c][t], end_r[c][t])) begin
                        overflow_r <= 1'b1;
                      end else begin
                        head_r[c][t]  <= next_ptr(head_r[c][t], start_r[c][t], end_r[c][t]);
                        count_r[c][t] <= count_r[c][t] + ONE_CNT;
                      end
                    end
                  end
                  OP_TAIL: begin
                    if (count_r[c][t] == '0) begin
                      underflow_r <= 1'b1;
                    end else begin
                      tail_r[c][t]  <= next_ptr(tail_r[c][t], start_r[c][t], end_r[c][t]);
                      count_r[c][t] <= count_r[c][t] - ONE_CNT;
                    end
                  end
                  OP_RTASK: begin
                    head_r[c][t]  <= start_r[c][t];
                    tail_r[c][t]  <= start_r[c][t];
                    count_r[c][t] <= '0;
                  end
                  default: begin
                  end
                endcase
              end
            end
          end
          case (op_r)
            OP_START, OP_END: csr_ack_r   <= 1'b1;
            OP_HEAD:          head_ack_r  <= 1'b1;
            OP_TAIL:          tail_ack_r  <= 1'b1;
            OP_RTASK:         rtask_ack_r <= 1'b1;
            default:          csr_ack_r   <= 1'b0;
          endcase
          state_r <= ST_ACK;
        end
        ST_ACK: begin
          csr_ack_r   <= 1'b0;
          head_ack_r  <= 1'b0;
          tail_ack_r  <= 1'b0;
          rtask_ack_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          csr_ack_r   <= 1'b0;
          head_ack_r  <= 1'b0;
          tail_ack_r  <= 1'b0;
          rtask_ack_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Producer lookup; out-of-range cores are clamped to index 0 and masked.
  always_comb begin
    rd_ok_s             = (int'(fprint_core_id) < NUM_CORES);
    rd_idx_s            = rd_ok_s ? fprint_core_id : 2'd0;
    fprint_head_pointer = '0;
    fprint_full         = 1'b0;
    if (rd_ok_s) begin
      fprint_head_pointer = head_r[rd_idx_s][fprint_task_id];
      fprint_full         = (count_r[rd_idx_s][fprint_task_id] ==
                             region_size(start_r[rd_idx_s][fprint_task_id],
                                         end_r[rd_idx_s][fprint_task_id]));
    end else begin
      fprint_head_pointer = '0;
      fprint_full         = 1'b0;
    end
  end

  // Comparator lookup across every core for the selected task.
  always_comb begin
    cmp_tail_pointer = '0;
    cmp_empty        = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      cmp_tail_pointer[c*ADDR_WIDTH +: ADDR_WIDTH] = tail_r[c][cmp_task_id];
      cmp_empty[c]                                 = (count_r[c][cmp_task_id] == '0);
    end
  end

  assign csr_ack             = csr_ack_r;
  assign fprint_inc_head_ack = head_ack_r;
  assign cmp_inc_tail_ack    = tail_ack_r;
  assign cmp_reset_task_ack  = rtask_ack_r;
  assign overflow_err        = overflow_r;
  assign underflow_err       = underflow_r;

endmodule
